hazard_ctrl: RTL
================

# hazard_ctrl

Pipeline sequencing controller for the 5-stage MIPS-subset CPU (IF/ID/EX/MEM/WB). It detects load-use and control hazards, generates per-stage enable/flush/bubble strobes and ALU operand forwarding selects, and freezes the whole pipeline while data memory reports busy. A pending-flush register and three saturating performance counters provide its sequential state. It sits beside the pipeline registers in `cpu` and is driven purely from stage-register fields.

## Interface
- `CNT_W`, 16, width of each performance counter
- `clk` in 1: rising-edge clock
- `rst_n` in 1: asynchronous, active-low reset
- `id_rs`, `id_rt` in 5: source registers of the instruction in ID
- `id_uses_rs`, `id_uses_rt` in 1: ID instruction reads that operand
- `ex_rs`, `ex_rt` in 5: source registers held in ID/EX
- `ex_rw` in 5, `ex_regwr` in 1, `ex_memtoreg` in 1: destination and flags of the instruction in EX
- `mem_rw` in 5, `mem_regwr` in 1: destination in EX/MEM
- `wb_rw` in 5, `wb_regwr` in 1: destination in MEM/WB
- `mem_br_taken` in 1: branch in MEM resolved taken (from EX/MEM zero/sign)
- `mem_busy` in 1: data memory not ready this cycle
- `pc_en`, `ifid_en`, `idex_en`, `exmem_en`, `memwb_en` out 1: stage-register load enables
- `ifid_flush`, `idex_flush`, `exmem_flush` out 1: load a NOP/bubble instead of the upstream value
- `pc_sel_br` out 1: PC loads the branch target
- `fwd_a`, `fwd_b` out 2: ALU operand source; 00 ID/EX bus, 10 EX/MEM ALUout, 01 MEM/WB busW
- `state` out 2: current FSM state, for debug
- `stall_cnt`, `flush_cnt`, `freeze_cnt` out CNT_W: performance counters

## Operation
- FSM states: RUN=00, LU_STALL=01, FREEZE=10, FLUSH=11. Hazard detection is combinational in the current cycle; state, `pend_br` and counters are registered.
- Priority within a cycle: `mem_busy` > branch > load-use.
- Load-use: `lu = ex_regwr & ex_memtoreg & ex_rw!=0 & ((id_uses_rs & id_rs==ex_rw) | (id_uses_rt & id_rt==ex_rw))`.
  - Effect: `pc_en=0`, `ifid_en=0`, `idex_flush=1`; other stages advance. Next state is LU_STALL.
  - LU_STALL: outputs as RUN and `lu` is re-evaluated. Because the bubble now occupies EX, it is normally false; the next state is RUN.
- Branch taken (`mem_br_taken` or `pend_br`, and not `mem_busy`):
  - Effect: `pc_sel_br=1`, `pc_en=1`, and `ifid_flush`, `idex_flush`, `exmem_flush` all 1.
  - `pend_br` clears. Next state is FLUSH for one cycle, with outputs as RUN; then RUN. Load-use is suppressed in the flush cycle.
- `mem_busy`: every `*_en` is 0 and every flush is 0. Next state is FREEZE.
  - If `mem_br_taken` is 1 during a freeze, `pend_br` is set. The branch is applied in the first cycle with `mem_busy`=0, even though `mem_br_taken` may then be stale.
  - Leaving FREEZE, detection resumes normally.
- Forwarding (EX operand A; B identical with `ex_rt`):
  - 10 if `mem_regwr & mem_rw!=0 & mem_rw==ex_rs`.
  - Else 01 if `wb_regwr & wb_rw!=0 & wb_rw==ex_rs`.
  - Else 00.
  - EX/MEM wins over MEM/WB. `fwd_*` is driven in every state, including FREEZE.
- Counters: `stall_cnt` increments on each load-use stall cycle, `flush_cnt` on each branch-flush cycle, `freeze_cnt` on each `mem_busy` cycle. Each saturates at all-ones and never wraps.

## Timing
- Reset (async assert, sync deassert by the flops): state=RUN, `pend_br`=0, counters=0.
  - During reset, enables=1, flushes=0, `pc_sel_br`=0, `fwd_*`=00.
- Zero-cycle latency from hazard inputs to strobes. Every strobe takes effect at the next `clk` edge.
- Load-use costs exactly one bubble. A taken branch costs three squashed slots.
- A simultaneous `lu` and branch flushes; the load-use stall is dropped because the ID instruction is squashed.
- `rst_n` asserted mid-freeze drops `pend_br`.

## Structure
- Package `hazard_pkg`:
  - state encoding constants.
  - `FWD_NONE`/`FWD_MEM`/`FWD_WB` codes.
- Sub-module `fwd_unit`: one combinational instance per operand (inputs `src`, `mem_*`, `wb_*`; output 2-bit select). The FSM, `pend_br` and counters live in `hazard_ctrl`.

## Test plan
- `lw $2` in EX with `id_rs`=2 and `id_uses_rs`=1 → one cycle of `pc_en`=0, `ifid_en`=0, `idex_flush`=1, `stall_cnt`=1, then RUN.
- `mem_rw`=`wb_rw`=5, both regwr, `ex_rs`=5 → `fwd_a`=10. Same with `mem_regwr`=0 → 01. With `mem_rw`=`wb_rw`=0 → 00.
- `mem_br_taken` pulse → all three flushes plus `pc_sel_br` in that cycle, state FLUSH the next cycle, `flush_cnt`=1.
- `mem_busy` for 3 cycles with `mem_br_taken` in the second → all enables 0 for 3 cycles, `freeze_cnt`=3, then the flush is applied in cycle 4.
- `lu` and `mem_br_taken` together → flush only, `stall_cnt` unchanged.
- Force `stall_cnt`=0xFFFF and cause another stall → it remains 0xFFFF. Pulse `rst_n` low mid-FREEZE → all counters 0 and state RUN immediately.

Source files
------------

// File: rtl/hazard_pkg.sv
// Shared encodings for the pipeline hazard controller:
// FSM state codes and ALU forwarding select codes.
package hazard_pkg;

    typedef enum logic [1:0] {
        RUN      = 2'b00,
        LU_STALL = 2'b01,
        FREEZE   = 2'b10,
        FLUSH    = 2'b11
    } state_t;

    localparam logic [1:0] FWD_NONE = 2'b00;
    localparam logic [1:0] FWD_MEM  = 2'b10;
    localparam logic [1:0] FWD_WB   = 2'b01;

endpackage

// File: rtl/hazard_ctrl_fwd_unit.sv
// Forwarding select for one ALU operand.
// The younger EX/MEM result wins over MEM/WB.
module fwd_unit
    import hazard_pkg::*;
(
    input  logic [4:0] src,
    input  logic [4:0] mem_rw,
    input  logic       mem_regwr,
    input  logic [4:0] wb_rw,
    input  logic       wb_regwr,
    output logic [1:0] sel
);

    logic hit_mem;
    logic hit_wb;

    assign hit_mem = mem_regwr & (mem_rw != 5'd0) & (mem_rw == src);
    assign hit_wb  = wb_regwr & (wb_rw != 5'd0) & (wb_rw == src);

    always_comb begin
        sel = FWD_NONE;
        if (hit_mem)
            sel = FWD_MEM;
        else if (hit_wb)
            sel = FWD_WB;
    end

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline sequencing: load-use stall, branch flush, memory freeze,
// operand forwarding and saturating performance counters.
module hazard_ctrl
    import hazard_pkg::*;
#(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [4:0]       id_rs,
    input  logic [4:0]       id_rt,
    input  logic             id_uses_rs,
    input  logic             id_uses_rt,
    input  logic [4:0]       ex_rs,
    input  logic [4:0]       ex_rt,
    input  logic [4:0]       ex_rw,
    input  logic             ex_regwr,
    input  logic             ex_memtoreg,
    input  logic [4:0]       mem_rw,
    input  logic             mem_regwr,
    input  logic [4:0]       wb_rw,
    input  logic             wb_regwr,
    input  logic             mem_br_taken,
    input  logic             mem_busy,
    output logic             pc_en,
    output logic             ifid_en,
    output logic             idex_en,
    output logic             exmem_en,
    output logic             memwb_en,
    output logic             ifid_flush,
    output logic             idex_flush,
    output logic             exmem_flush,
    output logic             pc_sel_br,
    output logic [1:0]       fwd_a,
    output logic [1:0]       fwd_b,
    output logic [1:0]       state,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt,
    output logic [CNT_W-1:0] freeze_cnt
);

    state_t           st_q;
    logic             pend_q;
    logic [CNT_W-1:0] stall_q;
    logic [CNT_W-1:0] flush_q;
    logic [CNT_W-1:0] freeze_q;

    logic       lu_rs;
    logic       lu_rt;
    logic       lu;
    logic       busy;
    logic       br;
    logic       lu_go;
    logic [1:0] sel_a;
    logic [1:0] sel_b;

    assign lu_rs = id_uses_rs & (id_rs == ex_rw);
    assign lu_rt = id_uses_rt & (id_rt == ex_rw);
    assign lu    = ex_regwr & ex_memtoreg & (ex_rw != 5'd0)
                 & (lu_rs | lu_rt);

    // Busy beats branch beats load-use; the three are made exclusive.
    assign busy  = mem_busy;
    assign br    = ~busy & (mem_br_taken | pend_q);
    assign lu_go = ~busy & ~br & (st_q != FLUSH) & lu;

    always_comb begin
        pc_en       = 1'b1;
        ifid_en     = 1'b1;
        idex_en     = 1'b1;
        exmem_en    = 1'b1;
        memwb_en    = 1'b1;
        ifid_flush  = 1'b0;
        idex_flush  = 1'b0;
        exmem_flush = 1'b0;
        pc_sel_br   = 1'b0;
        if (rst_n) begin
            unique case (1'b1)
                busy: begin
                    pc_en    = 1'b0;
                    ifid_en  = 1'b0;
                    idex_en  = 1'b0;
                    exmem_en = 1'b0;
                    memwb_en = 1'b0;
                end
                br: begin
                    pc_sel_br   = 1'b1;
                    ifid_flush  = 1'b1;
                    idex_flush  = 1'b1;
                    exmem_flush = 1'b1;
                end
                lu_go: begin
                    pc_en      = 1'b0;
                    ifid_en    = 1'b0;
                    idex_flush = 1'b1;
                end
                default: ;
            endcase
        end
    end

    fwd_unit u_fwd_a (
        .src       (ex_rs),
        .mem_rw    (mem_rw),
        .mem_regwr (mem_regwr),
        .wb_rw     (wb_rw),
        .wb_regwr  (wb_regwr),
        .sel       (sel_a)
    );

    fwd_unit u_fwd_b (
        .src       (ex_rt),
        .mem_rw    (mem_rw),
        .mem_regwr (mem_regwr),
        .wb_rw     (wb_rw),
        .wb_regwr  (wb_regwr),
        .sel       (sel_b)
    );

    assign fwd_a = rst_n ? sel_a : FWD_NONE;
    assign fwd_b = rst_n ? sel_b : FWD_NONE;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            st_q     <= RUN;
            pend_q   <= 1'b0;
            stall_q  <= '0;
            flush_q  <= '0;
            freeze_q <= '0;
        end else begin
            unique case (1'b1)
                busy: begin
                    st_q <= FREEZE;
                    if (mem_br_taken)
                        pend_q <= 1'b1;
                end
                br: begin
                    st_q   <= FLUSH;
                    pend_q <= 1'b0;
                end
                lu_go: st_q <= LU_STALL;
                default: st_q <= RUN;
            endcase
            if (lu_go && stall_q != '1)
                stall_q <= stall_q + CNT_W'(1);
            if (br && flush_q != '1)
                flush_q <= flush_q + CNT_W'(1);
            if (busy && freeze_q != '1)
                freeze_q <= freeze_q + CNT_W'(1);
        end
    end

    assign state      = st_q;
    assign stall_cnt  = stall_q;
    assign flush_cnt  = flush_q;
    assign freeze_cnt = freeze_q;

endmodule
